// File: rtl/pipe_skid_stage.sv
// Elastic two-entry pipeline stage (main + skid) with fully registered
// in_ready/out_valid/out_data, so no combinational handshake path crosses it.
module pipe_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept, issue;

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

    assign accept = in_valid & in_ready;
    assign issue  = main_v_q & out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Payload registers keep their contents; only the valids clear.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d    = 1'b1;
                main_data_d = in_data;
            end
        end else if (!skid_v_q) begin
            unique case ({accept, issue})
                2'b11: main_data_d = in_data;
                2'b10: begin
                    skid_v_d    = 1'b1;
                    skid_data_d = in_data;
                end
                2'b01: main_v_d = 1'b0;
                default: ;
            endcase
        end else if (issue) begin
            // Full: the skid entry moves up; upstream was already stalled.
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus a random run against a
// queue-based reference of the stage contents.
module tb_pipe_skid_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int vectors = 0;
    int errors  = 0;
    logic [WIDTH-1:0] mq[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    // Advance one edge; the reference is simply the ordered list of held beats.
    task automatic tick();
        bit acc, iss;
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            iss = out_ready && (mq.size() > 0);
            if (iss) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL por: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 0",
                     out_valid, in_ready, occupancy, out_data);
        end
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        vectors++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill: occ=%0d ready=%b, want 2 0", occupancy, in_ready);
        end
        reset = 1'b1; tick(); tick();
        reset = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 0",
                     out_valid, in_ready, occupancy, out_data);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i) || in_ready !== 1'b1 || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b data=%h ready=%b occ=%0d, want 1 %h 1 1",
                         i, out_valid, out_data, in_ready, occupancy, i);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        vectors++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: occ=%0d ready=%b, want 2 0", occupancy, in_ready);
        end
        in_data = 32'hC;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'hA || occupancy !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h occ=%0d, want 1 a 2",
                         c, out_valid, out_data, occupancy);
            end
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_rel_b: valid=%b data=%h ready=%b, want 1 b 1", out_valid, out_data, in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hC) begin
            errors++;
            $display("FAIL stall_rel_c: valid=%b data=%h, want 1 c", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stall_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        in_data = 32'h3; flush = 1'b1; tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: valid=%b occ=%0d ready=%b, want 0 0 1", out_valid, occupancy, in_ready);
        end
        flush = 1'b0; in_data = 32'h4; tick();
        in_data = 32'h5; flush = 1'b1; tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_accept: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
        flush = 1'b0; in_data = 32'h55; tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL flush_next: valid=%b data=%h occ=%0d, want 1 55 1", out_valid, out_data, occupancy);
        end
        in_valid = 1'b0; out_ready = 1'b1; tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_alone: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            // Upstream keeps a stalled beat unchanged until it is taken.
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                occupancy !== 2'(mq.size()) || (mq.size() > 0 && out_data !== mq[0])) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand[%0d]: valid=%b ready=%b occ=%0d data=%h, want %b %b %0d %h",
                             c, out_valid, in_ready, occupancy, out_data,
                             mq.size() > 0, mq.size() < 2, mq.size(), (mq.size() > 0) ? mq[0] : '0);
            end
            vectors++;
            if ((!out_valid && !in_ready) || occupancy > 2'd2) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand_inv[%0d]: valid=%b ready=%b occ=%0d", c, out_valid, in_ready, occupancy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
